// File: rtl/maxpool_col_stream_if.sv
// Stream bus between the conv array and the 2x2 max-pool stage.
// The master drives conv columns; the slave (pool stage) returns pooled columns.
interface maxpool_col_stream_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IN_ROWS    = 24,
    parameter int unsigned IN_COLS    = 24
);
    localparam int unsigned OUT_ROWS = IN_ROWS / 2;
    localparam int unsigned OUT_COLS = IN_COLS / 2;
    localparam int unsigned IdxW     = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    logic                                 clear;
    logic                                 valid_in;
    logic [IN_ROWS-1:0][DATA_WIDTH-1:0]   data_in;
    logic                                 valid_out;
    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0]  data_out;
    logic [IdxW-1:0]                      col_idx;
    logic                                 done;

    modport master (
        output clear, valid_in, data_in,
        input  valid_out, data_out, col_idx, done
    );

    modport slave (
        input  clear, valid_in, data_in,
        output valid_out, data_out, col_idx, done
    );
endinterface

// File: rtl/maxpool_col_stream.sv
// Streaming 2x2 max-pool: pairs adjacent row lanes within a column, then
// adjacent columns, emitting one pooled column per two accepted input columns.
module maxpool_col_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IN_ROWS    = 24,
    parameter int unsigned IN_COLS    = 24,
    parameter int unsigned RELU       = 1
) (
    input  logic                clk,
    input  logic                rst,
    maxpool_col_stream_if.slave bus
);
    localparam int unsigned OUT_ROWS = IN_ROWS / 2;
    localparam int unsigned OUT_COLS = IN_COLS / 2;
    localparam int unsigned IdxW     = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int unsigned ColW     = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

    if (((IN_ROWS % 2) != 0) || ((IN_COLS % 2) != 0) || (IN_COLS < 2) || (IN_ROWS < 2))
    begin : g_bad_params
        $error("maxpool_col_stream: IN_ROWS and IN_COLS must be even and nonzero");
    end

    logic [ColW-1:0]                     in_col_q, in_col_d;
    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [IdxW-1:0]                     idx_q, idx_d;
    logic                                valid_q, valid_d;
    logic                                done_q, done_d;

    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0] vmax;
    logic [OUT_ROWS-1:0][DATA_WIDTH-1:0] pooled;
    logic                                accept;
    logic                                odd;
    logic                                last;

    // clear wins over a coincident beat
    assign accept = bus.valid_in && !bus.clear;
    assign odd    = in_col_q[0];
    assign last   = (in_col_q == ColW'(IN_COLS - 1));

    // Vertical max of each adjacent row pair in the incoming column
    always_comb begin
        vmax = '0;
        for (int k = 0; k < OUT_ROWS; k++) begin
            vmax[k] = ($signed(bus.data_in[2*k]) > $signed(bus.data_in[2*k+1]))
                      ? bus.data_in[2*k] : bus.data_in[2*k+1];
        end
    end

    // Horizontal max against the held even column, then optional ReLU clamp
    always_comb begin
        pooled = '0;
        for (int k = 0; k < OUT_ROWS; k++) begin
            pooled[k] = ($signed(hold_q[k]) > $signed(vmax[k])) ? hold_q[k] : vmax[k];
            if ((RELU != 0) && pooled[k][DATA_WIDTH-1]) begin
                pooled[k] = '0;
            end
        end
    end

    // Column counter, pair hold and output register next-state
    always_comb begin
        in_col_d = in_col_q;
        hold_d   = hold_q;
        data_d   = data_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        if (bus.clear) begin
            in_col_d = '0;
        end else if (accept) begin
            in_col_d = last ? '0 : in_col_q + 1'b1;
            if (!odd) begin
                hold_d = vmax;
            end else begin
                data_d  = pooled;
                idx_d   = IdxW'(in_col_q >> 1);
                valid_d = 1'b1;
                done_d  = last;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col_q <= '0;
            hold_q   <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            in_col_q <= in_col_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.col_idx   = idx_q;
    assign bus.valid_out = valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_maxpool_col_stream.sv
// Bench for maxpool_col_stream: four parameterisations share one stimulus
// source; a per-beat reference model queues expected pooled columns with
// their due cycle, and each output is popped and compared.
module tb_maxpool_col_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              clear;
    logic              valid_in;
    logic [23:0][15:0] din;
    int                sel;

    maxpool_col_stream_if #(.DATA_WIDTH(16), .IN_ROWS(4), .IN_COLS(2)) if_a ();
    maxpool_col_stream_if #(.DATA_WIDTH(16), .IN_ROWS(4), .IN_COLS(2)) if_b ();
    maxpool_col_stream_if #(.DATA_WIDTH(16), .IN_ROWS(4), .IN_COLS(4)) if_c ();
    maxpool_col_stream_if #(.DATA_WIDTH(16), .IN_ROWS(24), .IN_COLS(24)) if_d ();

    assign if_a.clear    = clear;
    assign if_a.valid_in = valid_in && (sel == 0);
    assign if_a.data_in  = din[3:0];
    assign if_b.clear    = clear;
    assign if_b.valid_in = valid_in && (sel == 1);
    assign if_b.data_in  = din[3:0];
    assign if_c.clear    = clear;
    assign if_c.valid_in = valid_in && (sel == 2);
    assign if_c.data_in  = din[3:0];
    assign if_d.clear    = clear;
    assign if_d.valid_in = valid_in && (sel == 3);
    assign if_d.data_in  = din;

    maxpool_col_stream #(.DATA_WIDTH(16), .IN_ROWS(4), .IN_COLS(2), .RELU(0)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    maxpool_col_stream #(.DATA_WIDTH(16), .IN_ROWS(4), .IN_COLS(2), .RELU(1)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    maxpool_col_stream #(.DATA_WIDTH(16), .IN_ROWS(4), .IN_COLS(4), .RELU(0)) u_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));
    maxpool_col_stream #(.DATA_WIDTH(16), .IN_ROWS(24), .IN_COLS(24), .RELU(1)) u_d (
        .clk(clk), .rst(rst), .bus(if_d.slave));

    logic              obs_valid;
    logic              obs_done;
    logic [3:0]        obs_idx;
    logic [11:0][15:0] obs_data;

    // Observe the currently selected instance
    always_comb begin
        obs_valid = 1'b0;
        obs_done  = 1'b0;
        obs_idx   = '0;
        obs_data  = '0;
        case (sel)
            0: begin
                obs_valid = if_a.valid_out; obs_done = if_a.done;
                obs_idx = 4'(if_a.col_idx); obs_data[1:0] = if_a.data_out;
            end
            1: begin
                obs_valid = if_b.valid_out; obs_done = if_b.done;
                obs_idx = 4'(if_b.col_idx); obs_data[1:0] = if_b.data_out;
            end
            2: begin
                obs_valid = if_c.valid_out; obs_done = if_c.done;
                obs_idx = 4'(if_c.col_idx); obs_data[1:0] = if_c.data_out;
            end
            default: begin
                obs_valid = if_d.valid_out; obs_done = if_d.done;
                obs_idx = 4'(if_d.col_idx); obs_data = if_d.data_out;
            end
        endcase
    end

    typedef struct {
        logic [11:0][15:0] data;
        logic [3:0]        idx;
        logic              done;
        int                due;
    } exp_t;

    exp_t              q[$];
    int                n_assert = 0;
    int                n_fail = 0;
    int                cycle = 0;
    int                n_valid = 0;
    int                n_done = 0;
    int                m_rows = 4;
    int                m_cols = 2;
    bit                m_relu = 1'b0;
    int                m_col = 0;
    logic [11:0][15:0] m_hold = '0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cfg(input int rows, input int cols, input bit relu);
        m_rows = rows;
        m_cols = cols;
        m_relu = relu;
        m_col  = 0;
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        din    = '0;
        din[0] = 16'(a);
        din[1] = 16'(b);
        din[2] = 16'(c);
        din[3] = 16'(d);
    endtask

    task automatic check_out();
        exp_t e;
        if (obs_valid) begin
            n_valid++;
            if (obs_done) n_done++;
        end
        if (obs_valid || (q.size() != 0 && q[0].due <= cycle)) begin
            chk("valid_out", 192'(obs_valid), 192'(1));
            n_assert++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_output: observed data %0h expected no output", obs_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_cycle", 192'(cycle), 192'(e.due));
                chk("data_out", obs_data, e.data);
                chk("col_idx", 192'(obs_idx), 192'(e.idx));
                chk("done", 192'(obs_done), 192'(e.done));
            end
        end
    endtask

    // One clock: model the beat seen at this edge, then sample outputs 1 ns later
    task automatic step();
        exp_t e;
        logic signed [15:0] a, b, v, p;
        @(posedge clk);
        cycle++;
        if (rst || clear) begin
            m_col = 0;
        end else if (valid_in) begin
            e.data = '0;
            for (int k = 0; k < m_rows / 2; k++) begin
                a = din[2*k];
                b = din[2*k+1];
                v = (a > b) ? a : b;
                if (m_col % 2 == 0) begin
                    m_hold[k] = v;
                end else begin
                    p = ($signed(m_hold[k]) > v) ? m_hold[k] : v;
                    if (m_relu && p < 0) p = 0;
                    e.data[k] = p;
                end
            end
            if (m_col % 2 == 1) begin
                e.idx  = 4'(m_col / 2);
                e.done = (m_col == m_cols - 1);
                e.due  = cycle;
                q.push_back(e);
            end
            m_col = (m_col == m_cols - 1) ? 0 : m_col + 1;
        end
        #1;
        check_out();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; valid_in = 1'b0; din = '0; sel = 0;
        cfg(4, 2, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset state of every instance
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk("rst_valid", 192'(obs_valid), 192'(0));
            chk("rst_done", 192'(obs_done), 192'(0));
            chk("rst_idx", 192'(obs_idx), 192'(0));
            chk("rst_data", obs_data, 192'(0));
        end

        // Basic pool, no ReLU
        sel = 0; cfg(4, 2, 1'b0);
        valid_in = 1'b1;
        set4(1, 5, -3, -7); step();
        set4(4, 2, -9, -8); step();
        valid_in = 1'b0;
        chk("basic_valid", 192'(obs_valid), 192'(1));
        chk("basic_lane0", 192'(obs_data[0]), 192'(16'd5));
        chk("basic_lane1", 192'(obs_data[1]), 192'(16'hFFFD));
        chk("basic_idx", 192'(obs_idx), 192'(0));
        chk("basic_done", 192'(obs_done), 192'(1));
        step();
        chk("basic_pulse_end", 192'(obs_valid), 192'(0));
        chk("basic_hold_lane0", 192'(obs_data[0]), 192'(16'd5));

        // Same stimulus with ReLU
        sel = 1; cfg(4, 2, 1'b1);
        valid_in = 1'b1;
        set4(1, 5, -3, -7); step();
        set4(4, 2, -9, -8); step();
        valid_in = 1'b0;
        chk("relu_lane0", 192'(obs_data[0]), 192'(16'd5));
        chk("relu_lane1", 192'(obs_data[1]), 192'(16'd0));
        step();

        // Gapped input, 3 idle cycles between beats
        sel = 2; cfg(4, 4, 1'b0);
        for (int c = 0; c < 4; c++) begin
            set4(10 * c, 10 * c, 10 * c, 10 * c);
            valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            if (c == 1) begin
                chk("gap_out0", 192'(obs_data[0]), 192'(16'd10));
                chk("gap_idx0", 192'(obs_idx), 192'(0));
                chk("gap_done0", 192'(obs_done), 192'(0));
            end
            if (c == 3) begin
                chk("gap_out1", 192'(obs_data[1]), 192'(16'd30));
                chk("gap_idx1", 192'(obs_idx), 192'(1));
                chk("gap_done1", 192'(obs_done), 192'(1));
            end
            repeat (3) step();
        end

        // Signed extremes
        do_reset(); cfg(4, 4, 1'b0);
        valid_in = 1'b1;
        set4(32'h8000, 32'h7FFF, 32'h8000, 32'h7FFF); step();
        set4(32'hFFFF, 32'h8000, 32'hFFFF, 32'h8000); step();
        valid_in = 1'b0;
        chk("ext_lane0", 192'(obs_data[0]), 192'(16'h7FFF));
        chk("ext_lane1", 192'(obs_data[1]), 192'(16'h7FFF));
        step();

        // Mid-frame clear with a coincident beat
        do_reset(); cfg(4, 4, 1'b0);
        valid_in = 1'b1;
        set4(100, 100, 100, 100); step();
        clear = 1'b1;
        set4(50, 50, 50, 50); step();
        clear = 1'b0;
        chk("clr_no_out", 192'(obs_valid), 192'(0));
        set4(1, 1, 1, 1); step();
        set4(2, 2, 2, 2); step();
        valid_in = 1'b0;
        chk("clr_lane0", 192'(obs_data[0]), 192'(16'd2));
        chk("clr_lane1", 192'(obs_data[1]), 192'(16'd2));
        chk("clr_idx", 192'(obs_idx), 192'(0));
        chk("clr_valid", 192'(obs_valid), 192'(1));
        step(); step();

        // Two continuous default-size frames with random data
        do_reset(); sel = 3; cfg(24, 24, 1'b1);
        n_valid = 0; n_done = 0;
        valid_in = 1'b1;
        for (int i = 0; i < 48; i++) begin
            for (int r = 0; r < 24; r++) din[r] = 16'($urandom);
            step();
        end
        valid_in = 1'b0;
        step();
        chk("cont_pulses", 192'(n_valid), 192'(24));
        chk("cont_dones", 192'(n_done), 192'(2));

        // Repeat run, reset mid-frame
        valid_in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            for (int r = 0; r < 24; r++) din[r] = 16'($urandom);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid_in = 1'b0;
        chk("midrst_valid", 192'(obs_valid), 192'(0));
        chk("midrst_done", 192'(obs_done), 192'(0));
        chk("midrst_idx", 192'(obs_idx), 192'(0));
        chk("midrst_data", obs_data, 192'(0));
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 24; r++) din[r] = 16'($urandom);
            step();
        end
        valid_in = 1'b0;
        step(); step();
        chk("queue_drained", 192'(q.size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
